obstacle_spawner: RTL and testbench
===================================

OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 3, number of independent obstacle slots (1..8).
REQ-002 SHALL have parameter SCREEN_W, default 640, spawn x reference (right edge of obstacle = SCREEN_W + width).
REQ-003 SHALL have parameter MIN_GAP, default 40, minimum ticks between consecutive spawns.
REQ-004 SHALL have parameter GAP_MASK, default 8'h7F, mask applied to rnd for random extra gap.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port tick  input  1  frame-advance enable; state advances only when tick=1.
REQ-008 SHALL have port run  input  1  1 = spawning allowed; 0 = no new spawns, active obstacles keep moving.
REQ-009 SHALL have port rnd  input  8  random value, sampled at spawn and gap-load events.
REQ-010 SHALL have port speed  input  6  pixels per tick subtracted from x of every active slot.
REQ-011 SHALL have port obs_x  output  10*NUM_SLOTS  per-slot upper-right x; slot i at bits [10i+9:10i].
REQ-012 SHALL have port obs_y  output  10*NUM_SLOTS  per-slot top y.
REQ-013 SHALL have port obs_w  output  8*NUM_SLOTS  per-slot width.
REQ-014 SHALL have port obs_ht  output  8*NUM_SLOTS  per-slot height.
REQ-015 SHALL have port obs_active  output  NUM_SLOTS  slot i on screen and moving.
REQ-016 SHALL have port spawn_count  output  16  total spawns since reset, wraps at 65535->0.

Function
REQ-017 Each slot SHALL be a 2-state FSM: IDLE (inactive) and MOVE (active); IDLE->MOVE only on spawn, MOVE->IDLE only on retire.
REQ-018 A global gap counter SHALL decrement by 1 per tick while nonzero; spawn is eligible when counter=0, run=1, tick=1 and at least one slot is IDLE.
REQ-019 On a spawn, exactly one slot SHALL spawn: the lowest-index IDLE slot.
REQ-020 On a spawn, gap counter SHALL load MIN_GAP + (rnd & GAP_MASK), and spawn_count SHALL increment.
REQ-021 Type on spawn SHALL be rnd[1:0] mod 3: 0 = cactus (w=30, ht=80, y=360); 1 = high flyer (w=60, ht=30, y=375); 2 = low flyer (w=60, ht=30, y=405).
REQ-022 Spawned slot x SHALL be SCREEN_W + new width (670 for cactus, 700 for flyer), using the new type's width, not the previous one.
REQ-023 In MOVE, on each tick, if x > speed then x SHALL become x - speed; otherwise slot SHALL retire (IDLE) with no underflow wrap.
REQ-024 A slot retiring and a spawn in the same tick SHALL both take effect; a slot retiring that tick SHALL NOT be chosen for that tick's spawn.
REQ-025 When all slots are in MOVE and the gap counter is 0, the spawn SHALL be deferred (counter held at 0) until a slot retires.
REQ-026 IDLE slots SHALL hold x = SCREEN_W + width and their last y/w/ht; obs_active = 0.
REQ-027 speed = 0 SHALL freeze all x values (no retire); run = 0 SHALL block spawns but the gap counter SHALL keep counting.
REQ-028 With tick = 0, no register other than reset-driven ones SHALL change.
REQ-029 All outputs SHALL be registered; spawned values visible the cycle after the spawning tick.

Reset
REQ-030 While rst_n = 0 at a clk edge, all slots SHALL go IDLE as cactus (x=670, y=360, w=30, ht=80), obs_active = 0, spawn_count = 0, gap counter = MIN_GAP.
REQ-031 Reset SHALL take priority over tick and abort any obstacle mid-flight.

Verification
REQ-032 Reset then run=1, tick every cycle, rnd=0, speed=5 -> first spawn after exactly MIN_GAP+1 ticks (41st tick), slot 0 cactus x=670, spawn_count=1.
REQ-033 Single active cactus, speed=5, x=5 -> next tick slot 0 retires, obs_active[0]=0, x never 1023.
REQ-034 NUM_SLOTS=3, GAP_MASK=0, MIN_GAP=1, speed=1 -> slots 0,1,2 spawn on consecutive eligible ticks, then spawn deferred until first retire; retiring slot reused the tick after.
REQ-035 rnd=1 then rnd=2 at successive spawns -> y=375 then y=405, w=60, ht=30, x=700.
REQ-036 Assert rst_n=0 for one cycle with 2 slots in MOVE -> next cycle all obs_active=0, spawn_count=0, x=670.
REQ-037 run=0 for 200 ticks after reset -> no spawns, spawn_count=0; raising run with gap counter 0 -> spawn on next tick.

Source files
------------

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: a row of independent obstacle slots fed by a shared
// gap timer. The lowest free slot receives each new obstacle.

module obstacle_slot #(
    parameter int SCREEN_W = 640
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_spawn,
    input  logic [1:0] i_type,
    input  logic [5:0] i_speed,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic [7:0] o_w,
    output logic [7:0] o_ht,
    output logic       o_active
);
    typedef enum logic {S_IDLE, S_MOVE} state_t;

    localparam logic [9:0] X_CACTUS = 10'(SCREEN_W + 30);
    localparam logic [9:0] X_FLYER  = 10'(SCREEN_W + 60);

    state_t     r_state;
    logic [9:0] r_x, r_y;
    logic [7:0] r_w, r_ht;
    logic       r_active;
    logic [9:0] w_speed;

    assign w_speed = {4'd0, i_speed};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_x      <= X_CACTUS;
            r_y      <= 10'd360;
            r_w      <= 8'd30;
            r_ht     <= 8'd80;
            r_active <= 1'b0;
        end else if (i_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (i_spawn) begin
                        r_state  <= S_MOVE;
                        r_active <= 1'b1;
                        case (i_type)
                            2'd1: begin
                                r_x <= X_FLYER;  r_y <= 10'd375; r_w <= 8'd60; r_ht <= 8'd30;
                            end
                            2'd2: begin
                                r_x <= X_FLYER;  r_y <= 10'd405; r_w <= 8'd60; r_ht <= 8'd30;
                            end
                            default: begin
                                r_x <= X_CACTUS; r_y <= 10'd360; r_w <= 8'd30; r_ht <= 8'd80;
                            end
                        endcase
                    end
                end
                S_MOVE: begin
                    // Retire rather than subtract when the step would reach or pass zero.
                    if (r_x > w_speed) begin
                        r_x <= r_x - w_speed;
                    end else begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                        r_x      <= 10'(SCREEN_W) + {2'b00, r_w};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_w      = r_w;
    assign o_ht     = r_ht;
    assign o_active = r_active;
endmodule

module obstacle_spawner #(
    parameter int         NUM_SLOTS = 3,
    parameter int         SCREEN_W  = 640,
    parameter int         MIN_GAP   = 40,
    parameter logic [7:0] GAP_MASK  = 8'h7F
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      run,
    input  logic [7:0]                rnd,
    input  logic [5:0]                speed,
    output logic [10*NUM_SLOTS-1:0]   obs_x,
    output logic [10*NUM_SLOTS-1:0]   obs_y,
    output logic [8*NUM_SLOTS-1:0]    obs_w,
    output logic [8*NUM_SLOTS-1:0]    obs_ht,
    output logic [NUM_SLOTS-1:0]      obs_active,
    output logic [15:0]               spawn_count
);
    logic [15:0]          r_gap;
    logic [15:0]          r_count;
    logic [NUM_SLOTS-1:0] w_active;
    logic [NUM_SLOTS-1:0] w_free;
    logic [NUM_SLOTS-1:0] w_sel;
    logic                 w_spawn;

    // Free slots are judged before this tick's retirements take effect.
    assign w_free  = ~w_active;
    assign w_sel   = w_free & (~w_free + NUM_SLOTS'(1));
    assign w_spawn = tick & run & (r_gap == 16'd0) & (|w_free);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gap   <= 16'(MIN_GAP);
            r_count <= 16'd0;
        end else if (tick) begin
            if (w_spawn) begin
                r_gap   <= 16'(MIN_GAP) + {8'd0, rnd & GAP_MASK};
                r_count <= r_count + 16'd1;
            end else if (r_gap != 16'd0) begin
                r_gap <= r_gap - 16'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            obstacle_slot #(.SCREEN_W(SCREEN_W)) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_tick   (tick),
                .i_spawn  (w_spawn & w_sel[gi]),
                .i_type   (rnd[1:0]),
                .i_speed  (speed),
                .o_x      (obs_x[10*gi +: 10]),
                .o_y      (obs_y[10*gi +: 10]),
                .o_w      (obs_w[8*gi +: 8]),
                .o_ht     (obs_ht[8*gi +: 8]),
                .o_active (w_active[gi])
            );
        end
    endgenerate

    assign obs_active  = w_active;
    assign spawn_count = r_count;
endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a slot-list model of the spawner.

module tb_obstacle_spawner;
    localparam int NS = 3;
    localparam int SW = 640;
    localparam int MG = 40;
    localparam int GM = 8'h7F;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tick = 1'b0;
    logic            run = 1'b0;
    logic [7:0]      rnd = 8'd0;
    logic [5:0]      speed = 6'd0;
    logic [10*NS-1:0] obs_x, obs_y;
    logic [8*NS-1:0]  obs_w, obs_ht;
    logic [NS-1:0]    obs_active;
    logic [15:0]      spawn_count;

    int total = 0;
    int bad   = 0;

    int m_x[NS], m_y[NS], m_w[NS], m_h[NS];
    bit m_a[NS];
    int m_gap, m_cnt;

    obstacle_spawner #(.NUM_SLOTS(NS), .SCREEN_W(SW), .MIN_GAP(MG), .GAP_MASK(8'h7F)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .rnd(rnd), .speed(speed),
        .obs_x(obs_x), .obs_y(obs_y), .obs_w(obs_w), .obs_ht(obs_ht),
        .obs_active(obs_active), .spawn_count(spawn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_a[i] = 0; m_x[i] = SW + 30; m_y[i] = 360; m_w[i] = 30; m_h[i] = 80;
        end
        m_gap = MG;
        m_cnt = 0;
    endtask

    task automatic model_update();
        int  fi;
        int  ty;
        bit  sp;
        if (!rst_n) begin
            model_reset();
        end else if (tick) begin
            fi = -1;
            for (int i = 0; i < NS; i++) if (!m_a[i] && fi < 0) fi = i;
            sp = run && (m_gap == 0) && (fi >= 0);
            for (int i = 0; i < NS; i++) begin
                if (m_a[i]) begin
                    if (m_x[i] > int'(speed)) m_x[i] -= int'(speed);
                    else begin m_a[i] = 0; m_x[i] = SW + m_w[i]; end
                end
            end
            if (sp) begin
                ty = (int'(rnd) % 4) % 3;
                m_a[fi] = 1;
                m_w[fi] = (ty == 0) ? 30 : 60;
                m_h[fi] = (ty == 0) ? 80 : 30;
                m_y[fi] = (ty == 0) ? 360 : ((ty == 1) ? 375 : 405);
                m_x[fi] = SW + m_w[fi];
                m_gap   = MG + (int'(rnd) & GM);
                m_cnt   = (m_cnt + 1) % 65536;
            end else if (m_gap > 0) begin
                m_gap--;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("x%0d", i),  int'(obs_x[10*i +: 10]), m_x[i]);
            chk($sformatf("y%0d", i),  int'(obs_y[10*i +: 10]), m_y[i]);
            chk($sformatf("w%0d", i),  int'(obs_w[8*i +: 8]),   m_w[i]);
            chk($sformatf("ht%0d", i), int'(obs_ht[8*i +: 8]),  m_h[i]);
            chk($sformatf("act%0d", i), int'(obs_active[i]),    int'(m_a[i]));
        end
        chk("count", int'(spawn_count), m_cnt);
    endtask

    task automatic step(input bit r, input bit t, input bit ru, input int rn, input int sp);
        rst_n = r; tick = t; run = ru; rnd = 8'(rn); speed = 6'(sp);
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        #1;
        step(0, 1, 1, 0, 5);
        chk("rst_active", int'(obs_active), 0);
        chk("rst_x0", int'(obs_x[9:0]), 670);
        chk("rst_count", int'(spawn_count), 0);

        // First spawn after the reset-loaded gap expires.
        for (int k = 0; k < MG; k++) step(1, 1, 1, 0, 5);
        chk("pre_spawn_active", int'(obs_active), 0);
        step(1, 1, 1, 0, 5);
        chk("spawn41_act0", int'(obs_active[0]), 1);
        chk("spawn41_x0", int'(obs_x[9:0]), 670);
        chk("spawn41_count", int'(spawn_count), 1);

        // Retire without underflow.
        for (int k = 0; k < 133; k++) step(1, 1, 0, 0, 5);
        chk("near_edge_x0", int'(obs_x[9:0]), 5);
        step(1, 1, 0, 0, 5);
        chk("retire_act0", int'(obs_active[0]), 0);
        chk("retire_x0", int'(obs_x[9:0]), 670);

        // Flyer types.
        step(1, 1, 1, 1, 5);
        chk("hi_y", int'(obs_y[9:0]), 375);
        chk("hi_x", int'(obs_x[9:0]), 700);
        chk("hi_w", int'(obs_w[7:0]), 60);
        chk("hi_ht", int'(obs_ht[7:0]), 30);
        chk("hi_count", int'(spawn_count), 2);
        for (int k = 0; k < MG + 1; k++) step(1, 1, 1, 0, 5);
        step(1, 1, 1, 2, 5);
        chk("lo_y", int'(obs_y[19:10]), 405);
        chk("lo_x", int'(obs_x[19:10]), 700);
        chk("lo_act", int'(obs_active), 3);
        chk("hi_moved_x", int'(obs_x[9:0]), 700 - 5 * 42);

        // Mid-flight reset.
        step(0, 1, 1, 0, 5);
        chk("rst2_active", int'(obs_active), 0);
        chk("rst2_count", int'(spawn_count), 0);
        chk("rst2_x1", int'(obs_x[19:10]), 670);

        // run held low: timer still drains, spawn follows run rising.
        for (int k = 0; k < 200; k++) step(1, 1, 0, 0, 5);
        chk("runlow_count", int'(spawn_count), 0);
        step(1, 1, 1, 0, 5);
        chk("runhigh_count", int'(spawn_count), 1);
        chk("runhigh_act0", int'(obs_active[0]), 1);

        // Random traffic with occasional resets and idle cycles.
        for (int k = 0; k < 4000; k++)
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) != 0), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63)));

        // Slow traffic so every slot fills and spawns get deferred.
        for (int k = 0; k < 3000; k++)
            step(1, ($urandom_range(0, 7) != 0), 1, int'($urandom_range(0, 255)),
                 int'($urandom_range(1, 3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
